id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Execute-stage input pipeline register that sits directly upstream of the ALU. It captures decoded operands and control from the decode stage and selects register or immediate for the second operand. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB and detects load-use hazards. It drives `ALUCtrl`/`ALUOP1`/`ALUOP2` into the ALU and carries destination and write-enable information down the pipe.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width.
- `ALUCTRL_WIDTH`, 3, ALU opcode width.
- `REG_ADDR_WIDTH`, 5, register index width.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode stage presents a real instruction.
- `stall`  in  1  hold stage contents.
- `flush`  in  1  replace stage contents with a bubble.
- `ALUCtrl_in`  in  ALUCTRL_WIDTH  decoded ALU opcode.
- `ALUSrc_in`  in  1  1 = second operand is `imm`.
- `mem_read_in`  in  1  instruction is a load.
- `reg_write_in`  in  1  instruction writes `rd_in`.
- `rs1_addr`, `rs2_addr`, `rd_in`  in  REG_ADDR_WIDTH  decode register indices.
- `rs1_data`, `rs2_data`, `imm`  in  DATA_WIDTH  register file read data and sign-extended immediate.
- `exmem_reg_write`, `memwb_reg_write`  in  1  downstream writeback enables.
- `exmem_rd`, `memwb_rd`  in  REG_ADDR_WIDTH  downstream destinations.
- `exmem_result`, `memwb_result`  in  DATA_WIDTH  downstream results.
- `ex_valid`  out  1  stage holds a real instruction.
- `ALUCtrl`  out  ALUCTRL_WIDTH  to ALU.
- `ALUOP1`, `ALUOP2`  out  DATA_WIDTH  to ALU.
- `store_data`  out  DATA_WIDTH  forwarded rs2 value for stores.
- `rd_out`  out  REG_ADDR_WIDTH  destination passed downstream.
- `reg_write_out`, `mem_read_out`  out  1  gated by `ex_valid`.
- `load_use`  out  1  load-use hazard; decode must hold.

## Operation
- **Registered fields** (all updated on the rising edge): valid, ALUCtrl, ALUSrc, mem_read, reg_write, rs1/rs2/rd addresses, rs1/rs2 data, imm.
- **Update priority** at each edge, highest first:
  - `flush`: load a bubble.
  - `load_use`: load a bubble.
  - `stall`: hold contents.
  - Otherwise: capture inputs. If `in_valid`=0, the captured entry is a bubble.
- **Bubble:** valid=0, ALUCtrl=3'b000, all control bits 0, all addresses and data 0.
- **Forwarding** (combinational, per source operand, using registered address and data):
  - If `exmem_reg_write` and `exmem_rd`!=0 and `exmem_rd`==rsN_q, use `exmem_result`.
  - Else, the same test against MEM/WB, using `memwb_result`.
  - Else, use rsN_data_q.
  - EX/MEM always wins over MEM/WB. Register x0 is never forwarded.
- **Operand outputs:**
  - `ALUOP1` = fwd(rs1).
  - `ALUOP2` = ALUSrc_q ? imm_q : fwd(rs2).
  - `store_data` = fwd(rs2), regardless of ALUSrc_q.
- **Gated outputs:** `reg_write_out` = valid_q & reg_write_q; `mem_read_out` = valid_q & mem_read_q.
- **Load-use detection:** `load_use` = valid_q & mem_read_q & rd_q!=0 & `in_valid` & (rd_q==`rs1_addr` | rd_q==`rs2_addr`).
  - Combinational.
  - On that edge the stage inserts one bubble while decode holds the instruction.
  - Next cycle the load has moved to MEM, so forwarding from MEM/WB resolves the hazard.
- **No width conversion:** all data paths are DATA_WIDTH; `imm` is already extended.

## Timing
- Latency is 1 cycle from decode inputs to ALU operands. Forwarding adds no cycle.
- Reset: all registered fields are cleared asynchronously. Outputs settle to `ex_valid`=0, `ALUCtrl`=0, `ALUOP1`=0, `ALUOP2`=0, `store_data`=0, `rd_out`=0, `reg_write_out`=0, `mem_read_out`=0 and `load_use`=0, provided no forwarding input matches address 0. Address 0 is excluded from forwarding, so this always holds.
- A reset asserted mid-operation discards the in-flight instruction with no partial update.
- Simultaneous `flush`+`stall` results in a bubble.
- Simultaneous `stall`+`load_use` results in a bubble. The upstream stall still holds decode.
- While stalled, forwarded values may change as downstream stages advance. The outputs track them combinationally.

## Configuration
- Macro: `ID_EX_FORWARDING_EN`.
- **Defined:** forwarding muxes and `load_use` detection are built as described.
- **Undefined:**
  - `ALUOP1`=rs1_data_q.
  - `ALUOP2`=ALUSrc_q ? imm_q : rs2_data_q.
  - `store_data`=rs2_data_q.
  - `load_use` is tied to 0.
  - Forwarding ports are present but ignored.
  - Hazard avoidance is left to instruction scheduling.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with a valid instruction in the stage -> all outputs are 0 immediately, and `ex_valid`=0 after release.
- **Basic capture:** capture `rs1_data`=5, `rs2_data`=7, `ALUSrc_in`=0, `ALUCtrl_in`=001 -> next cycle `ALUOP1`=5, `ALUOP2`=7, `ALUCtrl`=001. Repeat with `ALUSrc_in`=1, `imm`=0xFFFFFFFC -> `ALUOP2`=0xFFFFFFFC and `store_data`=7.
- **Forwarding priority:** rs1_q=3, `exmem_rd`=3 with result 0x10, `memwb_rd`=3 with result 0x20, both write enables high -> `ALUOP1`=0x10. Drop `exmem_reg_write` -> `ALUOP1`=0x20. Set rs1_q=0 with both rd=0 -> `ALUOP1`=rs1_data_q.
- **Load-use:** load to x4 in EX; decode presents `rs2_addr`=4 -> `load_use`=1, next cycle `ex_valid`=0. When decode re-presents the instruction, it is captured and x4 is forwarded from MEM/WB.
- **Stall/flush:** assert `stall` for 3 cycles -> outputs are stable, with only the forwarded values changing. Assert `flush`+`stall` together -> bubble with `reg_write_out`=0.
- **Macro undefined:** repeat the forwarding-priority test -> `ALUOP1`=rs1_data_q, and `load_use` stays 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register that feeds the ALU.
// It selects the second operand from the register or the immediate, and
// forwards results from EX/MEM and MEM/WB.
// Optional build macro ID_EX_FORWARDING_EN adds the forwarding muxes and the
// load-use detector. Without it the raw register data is used and load_use
// is tied to 0.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUCTRL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [ALUCTRL_WIDTH-1:0]  ALUCtrl_in,
  input  logic                      ALUSrc_in,
  input  logic                      mem_read_in,
  input  logic                      reg_write_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic                      exmem_reg_write,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      ex_valid,
  output logic [ALUCTRL_WIDTH-1:0]  ALUCtrl,
  output logic [DATA_WIDTH-1:0]     ALUOP1,
  output logic [DATA_WIDTH-1:0]     ALUOP2,
  output logic [DATA_WIDTH-1:0]     store_data,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic                      reg_write_out,
  output logic                      mem_read_out,
  output logic                      load_use
);

  typedef struct packed {
    logic                      valid;
    logic [ALUCTRL_WIDTH-1:0]  alu_ctrl;
    logic                      alu_src;
    logic                      mem_read;
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
  } ex_entry_t;

  ex_entry_t              ex_q, ex_d;
  logic [DATA_WIDTH-1:0]  rs1_fwd, rs2_fwd;

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM beats MEM/WB. x0 is never forwarded because it is hardwired to zero.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0]     reg_val,
    input logic                      em_we,
    input logic [REG_ADDR_WIDTH-1:0] em_rd,
    input logic [DATA_WIDTH-1:0]     em_res,
    input logic                      mw_we,
    input logic [REG_ADDR_WIDTH-1:0] mw_rd,
    input logic [DATA_WIDTH-1:0]     mw_res
  );
    if (em_we && em_rd != '0 && em_rd == src)      return em_res;
    else if (mw_we && mw_rd != '0 && mw_rd == src) return mw_res;
    else                                           return reg_val;
  endfunction

  // Forwarded source operands, using the registered addresses and data.
  always_comb begin
    rs1_fwd = fwd_sel(ex_q.rs1, ex_q.rs1_data, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
    rs2_fwd = fwd_sel(ex_q.rs2, ex_q.rs2_data, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
  end

  // A load in EX whose result is needed by the instruction now in decode.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & in_valid &
                    ((ex_q.rd == rs1_addr) | (ex_q.rd == rs2_addr));
`else
  // Without forwarding, the register data is passed straight through.
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    rs2_fwd = ex_q.rs2_data;
  end

  assign load_use = 1'b0;

  // The forwarding ports and source addresses have no consumer in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
                        exmem_result, memwb_result, ex_q.rs1, ex_q.rs2};
`endif

  // Next entry. Priority: flush, then load-use bubble, then stall hold,
  // then capture. An invalid decode slot is captured as a bubble.
  always_comb begin
    ex_d = ex_q;
    if (flush || load_use) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d = '0;
      if (in_valid) begin
        ex_d.valid     = 1'b1;
        ex_d.alu_ctrl  = ALUCtrl_in;
        ex_d.alu_src   = ALUSrc_in;
        ex_d.mem_read  = mem_read_in;
        ex_d.reg_write = reg_write_in;
        ex_d.rs1       = rs1_addr;
        ex_d.rs2       = rs2_addr;
        ex_d.rd        = rd_in;
        ex_d.rs1_data  = rs1_data;
        ex_d.rs2_data  = rs2_data;
        ex_d.imm       = imm;
      end
    end
  end

  // Stage register. Reset clears every field at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ALUCtrl       = ex_q.alu_ctrl;
  assign ALUOP1        = rs1_fwd;
  assign ALUOP2        = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign store_data    = rs2_fwd;
  assign rd_out        = ex_q.rd;
  assign reg_write_out = ex_q.valid & ex_q.reg_write;
  assign mem_read_out  = ex_q.valid & ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. It keeps a behavioural model of the stage.
// Every cycle outside reset, the DUT outputs are compared to the model.
// A set of directed steps also checks hand-computed literal values.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, stall = 0, flush = 0;
  logic [2:0]  ALUCtrl_in = 0;
  logic        ALUSrc_in = 0, mem_read_in = 0, reg_write_in = 0;
  logic [4:0]  rs1_addr = 0, rs2_addr = 0, rd_in = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0;
  logic        exmem_reg_write = 0, memwb_reg_write = 0;
  logic [4:0]  exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;
  logic        ex_valid, reg_write_out, mem_read_out, load_use;
  logic [2:0]  ALUCtrl;
  logic [31:0] ALUOP1, ALUOP2, store_data;
  logic [4:0]  rd_out;

  int nchk = 0, npass = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ALUCtrl_in(ALUCtrl_in), .ALUSrc_in(ALUSrc_in), .mem_read_in(mem_read_in),
    .reg_write_in(reg_write_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_in(rd_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ALUCtrl(ALUCtrl), .ALUOP1(ALUOP1), .ALUOP2(ALUOP2),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .load_use(load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // One slot that holds either nothing (bubble) or an instruction record.
  typedef struct {
    bit          valid;
    bit [2:0]    ctrl;
    bit          src_imm, is_load, writes;
    bit [4:0]    rs1, rs2, rd;
    bit [31:0]   v1, v2, immv;
  } instr_t;

  instr_t slot;
  instr_t empty_slot;

  // Current register value seen by the ALU: newest in-flight producer first.
  function automatic logic [31:0] operand(input bit [4:0] r, input bit [31:0] regv);
    if (FWD && r != 0) begin
      if (exmem_reg_write && exmem_rd == r) return exmem_result;
      if (memwb_reg_write && memwb_rd == r) return memwb_result;
    end
    return regv;
  endfunction

  function automatic bit m_hazard();
    return FWD && slot.valid && slot.is_load && slot.rd != 0 && in_valid &&
           (slot.rd == rs1_addr || slot.rd == rs2_addr);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) slot <= empty_slot;
    else if (flush || m_hazard()) slot <= empty_slot;
    else if (!stall) begin
      if (!in_valid) slot <= empty_slot;
      else slot <= '{1'b1, ALUCtrl_in, ALUSrc_in, mem_read_in, reg_write_in,
                     rs1_addr, rs2_addr, rd_in, rs1_data, rs2_data, imm};
    end
  end

  // Compare the DUT outputs against the model on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_ex_valid",  {31'd0, ex_valid},      {31'd0, slot.valid});
      chk("m_aluctrl",   {29'd0, ALUCtrl},       {29'd0, slot.ctrl});
      chk("m_aluop1",    ALUOP1,                 operand(slot.rs1, slot.v1));
      chk("m_aluop2",    ALUOP2,                 slot.src_imm ? slot.immv : operand(slot.rs2, slot.v2));
      chk("m_store",     store_data,             operand(slot.rs2, slot.v2));
      chk("m_rd",        {27'd0, rd_out},        {27'd0, slot.rd});
      chk("m_rw",        {31'd0, reg_write_out}, {31'd0, slot.valid & slot.writes});
      chk("m_mr",        {31'd0, mem_read_out},  {31'd0, slot.valid & slot.is_load});
      chk("m_load_use",  {31'd0, load_use},      {31'd0, m_hazard()});
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input bit [2:0] c, input bit s, input bit ld, input bit w,
                       input bit [4:0] a1, input bit [4:0] a2, input bit [4:0] d,
                       input bit [31:0] x1, input bit [31:0] x2, input bit [31:0] im);
    in_valid = v; ALUCtrl_in = c; ALUSrc_in = s; mem_read_in = ld; reg_write_in = w;
    rs1_addr = a1; rs2_addr = a2; rd_in = d; rs1_data = x1; rs2_data = x2; imm = im;
  endtask

  task automatic downstream(input bit ew, input bit [4:0] er, input bit [31:0] ex,
                            input bit mw, input bit [4:0] mr, input bit [31:0] mx);
    exmem_reg_write = ew; exmem_rd = er; exmem_result = ex;
    memwb_reg_write = mw; memwb_rd = mr; memwb_result = mx;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    rst = 0;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_aluop2", ALUOP2, 32'd0);

    // Basic capture, register operand.
    drive(1, 3'b001, 0, 0, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    cyc();
    chk("cap_op1", ALUOP1, 32'd5);
    chk("cap_op2", ALUOP2, 32'd7);
    chk("cap_ctrl", {29'd0, ALUCtrl}, 32'd1);
    chk("cap_rw", {31'd0, reg_write_out}, 32'd1);
    // Immediate operand.
    drive(1, 3'b001, 1, 0, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'hFFFF_FFFC);
    cyc();
    chk("imm_op2", ALUOP2, 32'hFFFF_FFFC);
    chk("imm_store", store_data, 32'd7);

    // Forwarding priority on rs1 = x3. The stage is held while the downstream values change.
    drive(1, 3'b010, 0, 0, 1, 5'd3, 5'd2, 5'd9, 32'h99, 32'd7, 32'd0);
    cyc();
    stall = 1;
    downstream(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    #1 chk("fwd_exmem", ALUOP1, FWD ? 32'h10 : 32'h99);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", ALUOP1, FWD ? 32'h20 : 32'h99);
    // x0 source with both destinations x0: no forwarding.
    stall = 0;
    downstream(1, 5'd0, 32'h10, 1, 5'd0, 32'h20);
    drive(1, 3'b010, 0, 0, 1, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'd0);
    cyc();
    chk("fwd_x0", ALUOP1, 32'h55);
    downstream(0, 0, 0, 0, 0, 0);

    // Load-use: a load to x4, followed by a consumer of x4 in rs2.
    drive(1, 3'b000, 0, 1, 1, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0);
    cyc();
    chk("ld_mr", {31'd0, mem_read_out}, 32'd1);
    drive(1, 3'b011, 0, 0, 1, 5'd5, 5'd4, 5'd6, 32'h11, 32'hDEAD, 32'd0);
    #1 chk("lu_flag", {31'd0, load_use}, FWD ? 32'd1 : 32'd0);
    cyc();
    chk("lu_bubble", {31'd0, ex_valid}, FWD ? 32'd0 : 32'd1);
    downstream(0, 0, 0, 1, 5'd4, 32'h44);   // the load result is now visible downstream
    cyc();
    chk("lu_recap", {31'd0, ex_valid}, 32'd1);
    chk("lu_fwd", store_data, FWD ? 32'h44 : 32'hDEAD);
    chk("lu_op1", ALUOP1, 32'h11);
    downstream(0, 0, 0, 0, 0, 0);

    // Stall for 3 cycles. Only the forwarded operand may move.
    drive(1, 3'b100, 0, 0, 1, 5'd8, 5'd2, 5'd7, 32'h123, 32'h5, 32'd0);
    cyc();
    stall = 1;
    drive(1, 3'b111, 1, 1, 0, 5'd9, 5'd9, 5'd9, 32'hBAD, 32'hBAD, 32'hBAD);
    cyc();
    chk("stl_op1_a", ALUOP1, 32'h123);
    downstream(1, 5'd8, 32'h77, 0, 0, 0);
    cyc();
    chk("stl_rd", {27'd0, rd_out}, 32'd7);
    chk("stl_op1_b", ALUOP1, FWD ? 32'h77 : 32'h123);
    cyc();
    chk("stl_ctrl", {29'd0, ALUCtrl}, 32'd4);
    downstream(0, 0, 0, 0, 0, 0);
    flush = 1;
    cyc();
    flush = 0;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_rw", {31'd0, reg_write_out}, 32'd0);

    // stall together with load-use still gives a bubble.
    stall = 0;
    drive(1, 3'b000, 0, 1, 1, 5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0);
    cyc();
    stall = 1;
    drive(1, 3'b001, 0, 0, 1, 5'd10, 5'd3, 5'd11, 32'd3, 32'd4, 32'd0);
    cyc();
    chk("stlu_valid", {31'd0, ex_valid}, FWD ? 32'd0 : 32'd1);
    stall = 0;

    // Asynchronous reset in the middle of a cycle with a valid instruction held.
    drive(1, 3'b101, 1, 1, 1, 5'd1, 5'd2, 5'd12, 32'hA, 32'hB, 32'hC);
    cyc();
    #2 rst = 1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_op1", ALUOP1, 32'd0);
    chk("arst_op2", ALUOP2, 32'd0);
    chk("arst_store", store_data, 32'd0);
    chk("arst_rd", {27'd0, rd_out}, 32'd0);
    chk("arst_mr", {31'd0, mem_read_out}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 0;
    cyc();
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);
    cyc();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
